// File: rtl/boolean_lut_if.sv
// Operand/result handshake and truth-table config bundle for boolean_lut_unit.
// The master side drives operands and config; the slave side is the LUT unit.
interface boolean_lut_if #(
  parameter int WIDTH = 8,
  parameter int NFUNC = 4,
  parameter int CNT_W = 8
);
  localparam int SEL_W = $clog2(NFUNC);

  logic             ena;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [SEL_W-1:0] func_sel_i;
  logic             mode_i;
  logic             acc_clr_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] y_o;
  logic             parity_o;
  logic [CNT_W-1:0] cnt_o;
  logic             cfg_we_i;
  logic [SEL_W-1:0] cfg_sel_i;
  logic [3:0]       cfg_tt_i;

  modport master (
    output ena, a_i, b_i, func_sel_i, mode_i, acc_clr_i, in_valid_i, out_ready_i,
           cfg_we_i, cfg_sel_i, cfg_tt_i,
    input  in_ready_o, out_valid_o, y_o, parity_o, cnt_o
  );

  modport slave (
    input  ena, a_i, b_i, func_sel_i, mode_i, acc_clr_i, in_valid_i, out_ready_i,
           cfg_we_i, cfg_sel_i, cfg_tt_i,
    output in_ready_o, out_valid_o, y_o, parity_o, cnt_o
  );
endinterface

// File: rtl/boolean_lut_unit.sv
// Registered per-bit 2-input boolean unit with programmable truth tables,
// direct/accumulate modes, valid/ready handshake and a saturating beat counter.
module boolean_lut_unit #(
  parameter int WIDTH = 8,
  parameter int NFUNC = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  boolean_lut_if.slave  bus
);
  localparam int SEL_W = $clog2(NFUNC);

  // Power-up tables: AND, OR, XOR, pass-B; any further slots start as constant 0.
  function automatic logic [3:0] tt_reset(int slot);
    case (slot)
      0:       return 4'b1000;
      1:       return 4'b1110;
      2:       return 4'b0110;
      3:       return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  logic [3:0]       tt_q [NFUNC];
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] y_q;
  logic             parity_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] op_a;
  logic [3:0]       tt_cur;
  logic [WIDTH-1:0] result;

  assign in_ready = bus.ena & (~out_valid_q | bus.out_ready_i);
  assign accept   = bus.in_valid_i & in_ready;
  // Clear takes effect before a same-cycle accumulate beat is applied.
  assign acc_eff  = bus.acc_clr_i ? '0 : acc_q;
  assign op_a     = bus.mode_i ? acc_eff : bus.a_i;
  assign tt_cur   = tt_q[bus.func_sel_i];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result = '0;
    for (int k = 0; k < WIDTH; k++) begin
      result[k] = tt_cur[{op_a[k], bus.b_i[k]}];
    end
  end

  // NOTE: the table is tiny and has defined power-up contents, so it lives in
  // reset flops rather than a RAM; a table without reset values would not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NFUNC; i++) tt_q[i] <= tt_reset(i);
    end else if (bus.cfg_we_i && bus.ena) begin
      // Same-cycle beats read the old entry; the write lands at this edge.
      tt_q[bus.cfg_sel_i] <= bus.cfg_tt_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every block
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      y_q         <= '0;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (bus.acc_clr_i) acc_q <= '0;
      if (accept && bus.mode_i) acc_q <= result;

      if (accept) begin
        y_q         <= result;
        parity_q    <= ^result;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.y_o         = y_q;
  assign bus.parity_o    = parity_q;
  assign bus.cnt_o       = cnt_q;

  logic unused_sel;
  assign unused_sel = ^{SEL_W{1'b0}};
endmodule

// File: tb/tb_boolean_lut_unit.sv
// Scoreboard bench for boolean_lut_unit: expected results are queued at
// acceptance and compared when the output handshake completes.
module tb_boolean_lut_unit;
  localparam int WIDTH = 8;
  localparam int NFUNC = 4;
  localparam int CNT_W = 3;
  localparam int SEL_W = $clog2(NFUNC);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  boolean_lut_if #(.WIDTH(WIDTH), .NFUNC(NFUNC), .CNT_W(CNT_W)) bus ();

  boolean_lut_unit #(.WIDTH(WIDTH), .NFUNC(NFUNC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q [$];
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output side: stalled results must hold, completed handshakes pop the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(bus.out_valid_o), 32'd0);
      end else if (!bus.out_ready_i) begin
        check("hold_y", 32'(bus.y_o), 32'(exp_q[0]));
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("y", 32'(bus.y_o), 32'(e));
        check("parity", 32'(bus.parity_o), 32'(^e));
      end
    end
  end

  // Drive one beat, wait (bounded) for acceptance, then queue its expected result.
  task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [SEL_W-1:0] sel, input logic mode,
                      input logic clr, input logic [WIDTH-1:0] exp_y);
    logic ok;
    bus.a_i = a; bus.b_i = b; bus.func_sel_i = sel;
    bus.mode_i = mode; bus.acc_clr_i = clr; bus.in_valid_i = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready_o;
      @(posedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(exp_y);
      if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    end
    #1;
    bus.in_valid_i = 1'b0; bus.acc_clr_i = 1'b0; bus.cfg_we_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [SEL_W-1:0] sel, input logic [3:0] tt);
    bus.cfg_we_i = 1'b1; bus.cfg_sel_i = sel; bus.cfg_tt_i = tt;
    @(posedge clk); #1;
    bus.cfg_we_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid_o) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena = 1'b1; bus.a_i = '0; bus.b_i = '0; bus.func_sel_i = '0;
    bus.mode_i = 1'b0; bus.acc_clr_i = 1'b0; bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1; bus.cfg_we_i = 1'b0; bus.cfg_sel_i = '0; bus.cfg_tt_i = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_y", 32'(bus.y_o), 32'd0);
    check("rst_parity", 32'(bus.parity_o), 32'd0);
    check("rst_cnt", 32'(bus.cnt_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_idle", 32'(bus.in_ready_o), 32'd1);

    // Direct mode with default tables.
    beat(8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0, 8'h30);
    beat(8'hF0, 8'h3C, 2'd2, 1'b0, 1'b0, 8'hCC);
    drain();

    // Backpressure: second beat must wait while the first result is held.
    bus.out_ready_i = 1'b0;
    beat(8'hFF, 8'h0F, 2'd0, 1'b0, 1'b0, 8'h0F);
    bus.a_i = 8'h0F; bus.b_i = 8'h33; bus.func_sel_i = 2'd1; bus.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    beat(8'h0F, 8'h33, 2'd1, 1'b0, 1'b0, 8'h3F);
    drain();
    check("cnt_after_bp", 32'(bus.cnt_o), 32'(exp_cnt));

    // Config write with a same-cycle beat on the same slot sees the old table.
    bus.cfg_we_i = 1'b1; bus.cfg_sel_i = 2'd1; bus.cfg_tt_i = 4'b0001;
    beat(8'h0F, 8'h00, 2'd1, 1'b0, 1'b0, 8'h0F);
    beat(8'h0F, 8'h00, 2'd1, 1'b0, 1'b0, 8'hF0);
    cfg_write(2'd1, 4'b1110);

    // Accumulate chain.
    bus.acc_clr_i = 1'b1;
    @(posedge clk); #1;
    bus.acc_clr_i = 1'b0;
    beat(8'h00, 8'h01, 2'd1, 1'b1, 1'b0, 8'h01);
    beat(8'h00, 8'h02, 2'd1, 1'b1, 1'b0, 8'h03);
    beat(8'h00, 8'h80, 2'd1, 1'b1, 1'b0, 8'h83);
    beat(8'h00, 8'hFF, 2'd2, 1'b1, 1'b0, 8'h7C);
    // Clear concurrent with an accumulate beat: clear first, then apply.
    beat(8'h00, 8'h04, 2'd1, 1'b1, 1'b1, 8'h04);
    // A direct beat must leave the accumulator untouched.
    beat(8'hFF, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00);
    beat(8'h00, 8'h00, 2'd1, 1'b1, 1'b0, 8'h04);
    drain();

    // ena=0 blocks beats and config writes.
    bus.ena = 1'b0; bus.cfg_we_i = 1'b1; bus.cfg_sel_i = 2'd0; bus.cfg_tt_i = 4'b0000;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("dis_in_ready", 32'(bus.in_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    bus.cfg_we_i = 1'b0; bus.in_valid_i = 1'b0; bus.ena = 1'b1;
    beat(8'hFF, 8'hF5, 2'd0, 1'b0, 1'b0, 8'hF5);
    drain();
    check("cnt_saturated", 32'(bus.cnt_o), 32'd7);
    check("cnt_model", 32'(bus.cnt_o), 32'(exp_cnt));

    // Asynchronous reset with a pending stalled result.
    bus.out_ready_i = 1'b0;
    beat(8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0, 8'h30);
    cfg_write(2'd2, 4'b0000);
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("arst_y", 32'(bus.y_o), 32'd0);
    check("arst_parity", 32'(bus.parity_o), 32'd0);
    check("arst_cnt", 32'(bus.cnt_o), 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("in_rst_valid", 32'(bus.out_valid_o), 32'd0);
    end
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    beat(8'hF0, 8'h3C, 2'd2, 1'b0, 1'b0, 8'hCC);
    beat(8'hF0, 8'h3C, 2'd3, 1'b0, 1'b0, 8'h3C);
    drain();
    check("cnt_after_rst", 32'(bus.cnt_o), 32'd2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
